mips_fetch_top: RTL and testbench
=================================

// Module: mips_fetch_top
// PURPOSE
//  Instruction-fetch stage of the handshake-pipelined MIPS core. Holds the PC,
//  reads one word per instruction from a synchronous instruction memory, sends
//  {PC+4, instruction} to decode on channel f2d, then pulls a next-PC decision
//  back from decode on channel d2f. One instruction is in flight at a time.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC loaded on reset (word aligned)
//  SYNC_STAGES  2              flops in each ack synchronizer (>=2)
// PORTS
//  IM_CLK   in   1   single design clock; instruction memory shares it
//  Z_R      in   1   reset, asynchronous, active-high
//  IM_ADDR  out  32  byte address to instruction memory (registered)
//  IM_DATA  in   32  memory word; valid one IM_CLK cycle after IM_ADDR sampled
//  f2d_R    out  1   f2d request (4-phase, fetch is active side)
//  f2d      out  64  [63:32]=PC+4, [31:0]=instruction; stable while f2d_R=1
//  f2d_A    in   1   f2d acknowledge (asynchronous to IM_CLK)
//  d2f_R    out  1   d2f request (fetch pulls; 4-phase, fetch is active side)
//  d2f      in   33  [32]=take_branch, [31:0]=target; valid while d2f_A=1
//  d2f_A    in   1   d2f acknowledge (asynchronous to IM_CLK)
// BEHAVIOUR
//  - Reset (Z_R=1, async): PC=RESET_PC, IM_ADDR=RESET_PC, f2d=0, f2d_R=0,
//    d2f_R=0, state=FETCH, synchronizers cleared. Outputs hold while Z_R=1.
//  - f2d_A, d2f_A pass through SYNC_STAGES-flop synchronizers (fA_s, dA_s);
//    all FSM decisions use synchronized values only.
//  - IM_ADDR always equals PC register; PC[1:0] forced to 2'b00 on every load.
//  - FSM, all transitions on rising IM_CLK:
//    FETCH    : memory samples IM_ADDR this edge -> CAPTURE.
//    CAPTURE  : f2d<={PC+4, IM_DATA}; f2d_R<=1 -> SEND.
//    SEND     : if fA_s=1: f2d_R<=0 -> SEND_REL; else hold.
//    SEND_REL : if fA_s=0: d2f_R<=1 -> FB; else hold.
//    FB       : if dA_s=1: PC<= d2f[32] ? {d2f[31:2],2'b00} : PC+4;
//               d2f_R<=0 -> FB_REL; else hold.
//    FB_REL   : if dA_s=0 -> FETCH; else hold.
//  - Minimum 6 clocks per instruction plus synchronizer latency per ack edge.
//  - f2d is loaded only in CAPTURE; held constant through SEND..FB_REL and
//    next FETCH (bundled-data: never changes while f2d_R=1 or f2d_A=1).
//  - d2f sampled only in FB on the cycle dA_s first reads 1; later d2f
//    changes ignored.
//  - Request never deasserts before its synchronized ack rises; never
//    reasserts before synchronized ack falls (strict 4-phase).
//  - PC+4 arithmetic is modulo 2^32 (0xFFFF_FFFC+4 -> 0x0000_0000).
//  - Ack glitches/early acks while request low are ignored (state gated).
//  - Z_R asserted mid-handshake aborts immediately: both requests drop to 0,
//    PC=RESET_PC; after release the fetch restarts from RESET_PC.
//  - No output is combinationally dependent on any input.
// TESTING
//  - Reset: Z_R=1 then 0, mem[0]=0x2008_0005 -> IM_ADDR=0, first f2d =
//    {0x0000_0004, 0x2008_0005} with f2d_R=1; d2f_R=0 until f2d_A cycle done.
//  - Sequential: d2f always 33'h0, acks 10 ns after req -> f2d PC fields
//    4, 8, 12, 16... with instructions mem[0..3] in order.
//  - Branch: on 2nd d2f return 33'h1_0000_0040 -> IM_ADDR=0x40, next f2d =
//    {0x0000_0044, mem[16]}; then sequential 0x48 resumes.
//  - Misaligned target 33'h1_0000_0043 -> IM_ADDR=0x40.
//  - Slow ack: hold f2d_A low 20 clocks -> f2d_R and f2d stay stable, no new
//    IM_ADDR change, no d2f_R until f2d_A rises and falls.
//  - Reset mid-FB (d2f_R=1): assert Z_R -> d2f_R=0, f2d_R=0, IM_ADDR=0
//    asynchronously; after release first f2d PC field = 0x0000_0004.

Source files
------------

// File: rtl/mips_fetch_top.sv
// Instruction-fetch stage: holds the PC, reads a word from synchronous instruction memory,
// and runs two 4-phase handshakes: f2d to decode, then d2f back for the next-PC decision.
module mips_fetch_top #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        IM_CLK,
    input  logic        Z_R,
    output logic [31:0] IM_ADDR,
    input  logic [31:0] IM_DATA,
    output logic        f2d_R,
    output logic [63:0] f2d,
    input  logic        f2d_A,
    output logic        d2f_R,
    input  logic [32:0] d2f,
    input  logic        d2f_A
);

    typedef enum logic [2:0] {
        FETCH,
        CAPTURE,
        SEND,
        SEND_REL,
        FB,
        FB_REL
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t                 state_q, state_d;
    logic [31:0]            pc_q, pc_d;
    logic [63:0]            f2d_q, f2d_d;
    logic                   f2dReq_q, f2dReq_d;
    logic                   d2fReq_q, d2fReq_d;
    logic [SYNC_STAGES-1:0] fASync_q;
    logic [SYNC_STAGES-1:0] dASync_q;
    logic                   fA_s;
    logic                   dA_s;
    logic [31:0]            pcPlus4;

    // The acks come from another timing domain, so only the last synchronizer flop is trusted.
    always_ff @(posedge IM_CLK or posedge Z_R) begin
        if (Z_R) begin
            fASync_q <= '0;
            dASync_q <= '0;
        end else begin
            fASync_q <= {fASync_q[SYNC_STAGES-2:0], f2d_A};
            dASync_q <= {dASync_q[SYNC_STAGES-2:0], d2f_A};
        end
    end

    assign fA_s    = fASync_q[SYNC_STAGES-1];
    assign dA_s    = dASync_q[SYNC_STAGES-1];
    assign pcPlus4 = pc_q + 32'd4;

    always_ff @(posedge IM_CLK or posedge Z_R) begin
        if (Z_R) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC_ALIGNED;
            f2d_q    <= '0;
            f2dReq_q <= 1'b0;
            d2fReq_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            f2d_q    <= f2d_d;
            f2dReq_q <= f2dReq_d;
            d2fReq_q <= d2fReq_d;
        end
    end

    // Each request is only touched after its synchronized ack has reached the opposite level.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        f2d_d    = f2d_q;
        f2dReq_d = f2dReq_q;
        d2fReq_d = d2fReq_q;
        unique case (state_q)
            FETCH: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                f2d_d    = {pcPlus4, IM_DATA};
                f2dReq_d = 1'b1;
                state_d  = SEND;
            end
            SEND: begin
                if (fA_s) begin
                    f2dReq_d = 1'b0;
                    state_d  = SEND_REL;
                end
            end
            SEND_REL: begin
                if (!fA_s) begin
                    d2fReq_d = 1'b1;
                    state_d  = FB;
                end
            end
            FB: begin
                if (dA_s) begin
                    pc_d     = d2f[32] ? {d2f[31:2], 2'b00} : {pcPlus4[31:2], 2'b00};
                    d2fReq_d = 1'b0;
                    state_d  = FB_REL;
                end
            end
            FB_REL: begin
                if (!dA_s) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign IM_ADDR = pc_q;
    assign f2d     = f2d_q;
    assign f2d_R   = f2dReq_q;
    assign d2f_R   = d2fReq_q;

endmodule

// File: tb/tb_mips_fetch_top.sv
// Testbench for mips_fetch_top: acts as instruction memory and as the decode side of both
// handshakes, comparing every f2d word against a PC-tracking reference model.
`timescale 1ns/1ps
module tb_mips_fetch_top;

    logic        IM_CLK = 1'b0;
    logic        Z_R;
    logic [31:0] IM_ADDR;
    logic [31:0] IM_DATA;
    logic        f2d_R;
    logic [63:0] f2d;
    logic        f2d_A;
    logic        d2f_R;
    logic [32:0] d2f;
    logic        d2f_A;

    logic [31:0] mem [0:255];
    logic [31:0] pcModel;
    int          checks = 0;
    int          errors = 0;

    mips_fetch_top #(
        .RESET_PC   (32'h0000_0000),
        .SYNC_STAGES(2)
    ) dut (
        .IM_CLK (IM_CLK),
        .Z_R    (Z_R),
        .IM_ADDR(IM_ADDR),
        .IM_DATA(IM_DATA),
        .f2d_R  (f2d_R),
        .f2d    (f2d),
        .f2d_A  (f2d_A),
        .d2f_R  (d2f_R),
        .d2f    (d2f),
        .d2f_A  (d2f_A)
    );

    always #5 IM_CLK = ~IM_CLK;

    // Synchronous instruction memory, 256 words aliased over the address space.
    always @(posedge IM_CLK) IM_DATA <= mem[IM_ADDR[9:2]];

    function automatic logic [63:0] expectedF2d();
        return {pcModel + 32'd4, mem[pcModel[9:2]]};
    endfunction

    function automatic logic [31:0] nextPc(input logic [32:0] fb);
        if (fb[32]) return fb[31:0] & 32'hFFFF_FFFC;
        return pcModel + 32'd4;
    endfunction

    // Acks are driven from the negedge plus an odd offset so they never land on a rising edge.
    task automatic ackWait();
        #(10 * $urandom_range(0, 2) + 13);
    endtask

    task automatic waitSig(input int which, input logic level, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge IM_CLK);
            if (((which == 0) ? f2d_R : d2f_R) === level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic f2dCycle(output logic [63:0] seen, output logic [31:0] addrSeen, output bit ok);
        bit o1, o2;
        waitSig(0, 1'b1, o1);
        seen     = f2d;
        addrSeen = IM_ADDR;
        ackWait();
        f2d_A = 1'b1;
        waitSig(0, 1'b0, o2);
        ackWait();
        f2d_A = 1'b0;
        ok = o1 && o2;
    endtask

    task automatic d2fCycle(input logic [32:0] fb, output bit ok);
        bit o1, o2;
        waitSig(1, 1'b1, o1);
        d2f = fb;
        ackWait();
        d2f_A = 1'b1;
        waitSig(1, 1'b0, o2);
        d2f = {1'($urandom), $urandom};
        ackWait();
        d2f_A = 1'b0;
        ok = o1 && o2;
    endtask

    task automatic applyReset();
        Z_R   = 1'b1;
        f2d_A = 1'b0;
        d2f_A = 1'b0;
        d2f   = '0;
        repeat (2) @(negedge IM_CLK);
        Z_R     = 1'b0;
        pcModel = 32'h0000_0000;
    endtask

    task automatic test_reset();
        bit ok;
        Z_R   = 1'b1;
        f2d_A = 1'b0;
        d2f_A = 1'b0;
        d2f   = '0;
        repeat (3) @(negedge IM_CLK);
        checks++;
        if (IM_ADDR !== 32'h0) begin errors++; $display("[TB] FAIL reset_im_addr: got %h expected %h", IM_ADDR, 32'h0); end
        checks++;
        if (f2d_R !== 1'b0) begin errors++; $display("[TB] FAIL reset_f2d_R: got %b expected 0", f2d_R); end
        checks++;
        if (d2f_R !== 1'b0) begin errors++; $display("[TB] FAIL reset_d2f_R: got %b expected 0", d2f_R); end
        checks++;
        if (f2d !== 64'h0) begin errors++; $display("[TB] FAIL reset_f2d: got %h expected 0", f2d); end
        Z_R     = 1'b0;
        pcModel = 32'h0;
        waitSig(0, 1'b1, ok);
        checks++;
        if (!ok || f2d !== {32'h0000_0004, 32'h2008_0005}) begin
            errors++; $display("[TB] FAIL reset_first_f2d: got %h expected %h", f2d, {32'h0000_0004, 32'h2008_0005});
        end
        checks++;
        if (d2f_R !== 1'b0) begin errors++; $display("[TB] FAIL reset_d2f_early: got %b expected 0", d2f_R); end
        ackWait();
        f2d_A = 1'b1;
        waitSig(0, 1'b0, ok);
        checks++;
        if (!ok || d2f_R !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_d2f_before_ack_fall: got %b expected 0 (ok=%0d)", d2f_R, ok);
        end
        ackWait();
        f2d_A = 1'b0;
        d2fCycle(33'h0, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL reset_d2f_timeout: got timeout expected handshake"); end
        pcModel = 32'h4;
    endtask

    task automatic test_sequential();
        logic [63:0] seen;
        logic [31:0] addr;
        bit          ok1, ok2;
        applyReset();
        for (int i = 0; i < 4; i++) begin
            f2dCycle(seen, addr, ok1);
            checks++;
            if (!ok1 || seen !== expectedF2d() || seen[63:32] !== 32'(4 * (i + 1))) begin
                errors++; $display("[TB] FAIL seq_f2d_%0d: got %h expected %h", i, seen, expectedF2d());
            end
            d2fCycle(33'h0, ok2);
            checks++;
            if (!ok2) begin errors++; $display("[TB] FAIL seq_d2f_%0d: got timeout expected handshake", i); end
            pcModel = nextPc(33'h0);
        end
    endtask

    task automatic test_branch(input logic [32:0] target, input string name);
        logic [63:0] seen;
        logic [31:0] addr;
        logic [32:0] fb;
        bit          ok1, ok2;
        applyReset();
        for (int i = 0; i < 4; i++) begin
            fb = (i == 1) ? target : 33'h0;
            f2dCycle(seen, addr, ok1);
            checks++;
            if (!ok1 || seen !== expectedF2d() || addr !== pcModel) begin
                errors++; $display("[TB] FAIL %s_f2d_%0d: got %h @%h expected %h @%h", name, i, seen, addr, expectedF2d(), pcModel);
            end
            if (i == 2) begin
                checks++;
                if (addr !== 32'h0000_0040 || seen[63:32] !== 32'h0000_0044) begin
                    errors++; $display("[TB] FAIL %s_target: got addr %h pc4 %h expected 00000040 00000044", name, addr, seen[63:32]);
                end
            end
            if (i == 3) begin
                checks++;
                if (seen[63:32] !== 32'h0000_0048) begin
                    errors++; $display("[TB] FAIL %s_resume: got %h expected 00000048", name, seen[63:32]);
                end
            end
            d2fCycle(fb, ok2);
            checks++;
            if (!ok2) begin errors++; $display("[TB] FAIL %s_d2f_%0d: got timeout expected handshake", name, i); end
            pcModel = nextPc(fb);
        end
    endtask

    task automatic test_slow_ack();
        logic [63:0] held;
        logic [31:0] heldAddr;
        bit          ok;
        applyReset();
        waitSig(0, 1'b1, ok);
        held     = f2d;
        heldAddr = IM_ADDR;
        checks++;
        if (!ok || held !== expectedF2d()) begin
            errors++; $display("[TB] FAIL slow_first: got %h expected %h", held, expectedF2d());
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge IM_CLK);
            checks++;
            if (f2d_R !== 1'b1 || f2d !== held || IM_ADDR !== heldAddr || d2f_R !== 1'b0) begin
                errors++;
                $display("[TB] FAIL slow_hold_%0d: got R=%b f2d=%h addr=%h d2fR=%b expected R=1 f2d=%h addr=%h d2fR=0",
                         i, f2d_R, f2d, IM_ADDR, d2f_R, held, heldAddr);
            end
        end
        f2d_A = 1'b1;
        waitSig(0, 1'b0, ok);
        repeat (5) @(negedge IM_CLK);
        checks++;
        if (!ok || d2f_R !== 1'b0 || f2d !== held) begin
            errors++; $display("[TB] FAIL slow_release: got d2fR=%b f2d=%h expected d2fR=0 f2d=%h", d2f_R, f2d, held);
        end
        f2d_A = 1'b0;
        d2fCycle(33'h0, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL slow_d2f: got timeout expected handshake"); end
        pcModel = nextPc(33'h0);
    endtask

    task automatic test_wrap();
        logic [63:0] seen;
        logic [31:0] addr;
        bit          ok1, ok2;
        applyReset();
        f2dCycle(seen, addr, ok1);
        d2fCycle(33'h1_FFFF_FFFC, ok2);
        pcModel = nextPc(33'h1_FFFF_FFFC);
        f2dCycle(seen, addr, ok1);
        checks++;
        if (!ok1 || !ok2 || seen !== {32'h0000_0000, mem[255]} || addr !== 32'hFFFF_FFFC) begin
            errors++; $display("[TB] FAIL wrap_f2d: got %h @%h expected %h @fffffffc", seen, addr, {32'h0, mem[255]});
        end
        d2fCycle(33'h0, ok2);
        pcModel = nextPc(33'h0);
        f2dCycle(seen, addr, ok1);
        checks++;
        if (!ok1 || !ok2 || addr !== 32'h0 || seen !== expectedF2d()) begin
            errors++; $display("[TB] FAIL wrap_next: got %h @%h expected %h @00000000", seen, addr, expectedF2d());
        end
        d2fCycle(33'h0, ok2);
        pcModel = nextPc(33'h0);
    endtask

    task automatic test_random();
        logic [63:0] seen;
        logic [31:0] addr;
        logic [32:0] fb;
        bit          ok1, ok2;
        applyReset();
        for (int i = 0; i < 25; i++) begin
            fb = {($urandom_range(0, 3) == 0), $urandom};
            f2dCycle(seen, addr, ok1);
            checks++;
            if (!ok1 || seen !== expectedF2d() || addr !== pcModel) begin
                errors++; $display("[TB] FAIL rand_f2d_%0d: got %h @%h expected %h @%h", i, seen, addr, expectedF2d(), pcModel);
            end
            d2fCycle(fb, ok2);
            if (!ok2) begin
                checks++; errors++;
                $display("[TB] FAIL rand_d2f_%0d: got timeout expected handshake", i);
            end
            pcModel = nextPc(fb);
        end
    endtask

    task automatic test_reset_mid_fb();
        logic [63:0] seen;
        logic [31:0] addr;
        bit          ok1, ok2;
        applyReset();
        f2dCycle(seen, addr, ok1);
        d2fCycle(33'h1_0000_0080, ok2);
        pcModel = nextPc(33'h1_0000_0080);
        f2dCycle(seen, addr, ok1);
        waitSig(1, 1'b1, ok2);
        #2;
        Z_R = 1'b1;
        #1;
        checks++;
        if (!ok2 || d2f_R !== 1'b0 || f2d_R !== 1'b0 || IM_ADDR !== 32'h0) begin
            errors++; $display("[TB] FAIL midfb_async: got d2fR=%b f2dR=%b addr=%h expected 0 0 00000000", d2f_R, f2d_R, IM_ADDR);
        end
        repeat (2) @(negedge IM_CLK);
        Z_R     = 1'b0;
        pcModel = 32'h0;
        f2dCycle(seen, addr, ok1);
        checks++;
        if (!ok1 || seen[63:32] !== 32'h0000_0004 || seen !== expectedF2d()) begin
            errors++; $display("[TB] FAIL midfb_restart: got %h expected %h", seen, expectedF2d());
        end
        d2fCycle(33'h0, ok2);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h2008_0005;
        test_reset();
        test_sequential();
        test_branch(33'h1_0000_0040, "branch");
        test_branch(33'h1_0000_0043, "misaligned");
        test_slow_ack();
        test_wrap();
        test_random();
        test_reset_mid_fb();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
